// File: rtl/cic_rate_ctrl.sv
// Reconfiguration sequencer for the CIC decimator: flushes the integrator/comb
// chain on a factor change, loads the new factor, then masks the start-up transient.
module cic_rate_ctrl #(
  parameter int NumStages      = 3,
  parameter int FlushCycles    = 4,
  parameter int SettleCntWidth = 4
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic [2:0] CfgFactor_i,
  input  logic       CfgReq_i,
  output logic       CfgAck_o,
  output logic       Busy_o,
  output logic [1:0] State_o,
  output logic       FilterRst_o,
  output logic [2:0] DecimFactor_o,
  input  logic       OutVal_i,
  output logic       DataVal_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [3:0]                FlushLast  = 4'(FlushCycles - 1);
  localparam logic [SettleCntWidth-1:0] SettleLast = SettleCntWidth'(NumStages - 1);

  state_e                    state_q;
  logic [3:0]                flush_cnt_q;
  logic [SettleCntWidth-1:0] settle_cnt_q;
  logic [2:0]                pend_q;
  logic [2:0]                decim_q;
  logic                      ack_req_q;
  logic                      redo_q;
  logic                      ack_q;
  logic                      filter_rst_q;
  logic [2:0]                pend_d;

  // Factors 0 and 1 both mean "no decimation".
  assign pend_d = (CfgFactor_i <= 3'd1) ? 3'd1 : CfgFactor_i;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q      <= ST_FLUSH;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      pend_q       <= 3'd1;
      decim_q      <= 3'd1;
      ack_req_q    <= 1'b0;
      redo_q       <= 1'b0;
      ack_q        <= 1'b0;
      filter_rst_q <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (CfgReq_i) begin
            if (pend_d == decim_q) begin
              ack_q <= 1'b1;
            end else begin
              pend_q       <= pend_d;
              ack_req_q    <= 1'b1;
              flush_cnt_q  <= '0;
              filter_rst_q <= 1'b1;
              state_q      <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (CfgReq_i) begin
            pend_q    <= pend_d;
            ack_req_q <= 1'b1;
          end
          if (flush_cnt_q == FlushLast) begin
            filter_rst_q <= 1'b0;
            state_q      <= ST_LOAD;
          end else begin
            flush_cnt_q <= flush_cnt_q + 4'd1;
          end
        end

        ST_LOAD: begin
          decim_q      <= pend_q;
          ack_q        <= ack_req_q;
          ack_req_q    <= 1'b0;
          settle_cnt_q <= '0;
          state_q      <= ST_SETTLE;
          // NOTE: the last non-blocking assignment in the block wins, so a
          // request arriving in this cycle re-arms ack_req_q cleared above.
          if (CfgReq_i) begin
            pend_q    <= pend_d;
            ack_req_q <= 1'b1;
            redo_q    <= 1'b1;
          end
        end

        ST_SETTLE: begin
          // A new request always beats a simultaneous exit strobe.
          if (CfgReq_i || redo_q) begin
            if (CfgReq_i) begin
              pend_q <= pend_d;
            end
            ack_req_q    <= 1'b1;
            redo_q       <= 1'b0;
            flush_cnt_q  <= '0;
            filter_rst_q <= 1'b1;
            state_q      <= ST_FLUSH;
          end else if (OutVal_i) begin
            if (settle_cnt_q == SettleLast) begin
              state_q <= ST_RUN;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign CfgAck_o      = ack_q;
  assign State_o       = state_q;
  assign Busy_o        = (state_q != ST_RUN);
  assign FilterRst_o   = filter_rst_q;
  assign DecimFactor_o = decim_q;
  assign DataVal_o     = OutVal_i & (state_q == ST_RUN);

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Bench for cic_rate_ctrl: a phase/countdown model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_cic_rate_ctrl;

  localparam int NS = 3;
  localparam int FC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fac = 3'd0;
  logic       req = 1'b0;
  logic       ov  = 1'b1;
  logic       cfg_ack, busy, filter_rst, data_val;
  logic [1:0] state;
  logic [2:0] decim;

  always #5 clk = ~clk;

  cic_rate_ctrl #(.NumStages(NS), .FlushCycles(FC), .SettleCntWidth(4)) dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .CfgFactor_i  (fac),
    .CfgReq_i     (req),
    .CfgAck_o     (cfg_ack),
    .Busy_o       (busy),
    .State_o      (state),
    .FilterRst_o  (filter_rst),
    .DecimFactor_o(decim),
    .OutVal_i     (ov),
    .DataVal_o    (data_val)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: clocks of flush left, a one-cycle load flag, strobes still to mask.
  typedef struct packed {
    logic [4:0] flush_left;
    logic       loading;
    logic [3:0] mask_left;
    logic [2:0] factor;
    logic [2:0] pend;
    logic       owed;
    logic       redo;
    logic       ack;
  } model_t;

  model_t m = '0;
  logic   chk_en = 1'b0;

  function automatic model_t model_next(model_t c, logic r, logic q, logic [2:0] f, logic o);
    model_t     n  = c;
    logic [2:0] cf = (f <= 3'd1) ? 3'd1 : f;
    n.ack = 1'b0;
    if (r) begin
      n = '0;
      n.flush_left = 5'(FC);
      n.factor     = 3'd1;
      n.pend       = 3'd1;
    end else if (c.flush_left != 5'd0) begin
      if (q) begin
        n.pend = cf;
        n.owed = 1'b1;
      end
      n.flush_left = c.flush_left - 5'd1;
      n.loading    = (c.flush_left == 5'd1);
    end else if (c.loading) begin
      n.factor    = c.pend;
      n.ack       = c.owed;
      n.owed      = 1'b0;
      n.loading   = 1'b0;
      n.mask_left = 4'(NS);
      if (q) begin
        n.pend = cf;
        n.owed = 1'b1;
        n.redo = 1'b1;
      end
    end else if (c.mask_left != 4'd0) begin
      if (q || c.redo) begin
        if (q) n.pend = cf;
        n.owed       = 1'b1;
        n.redo       = 1'b0;
        n.flush_left = 5'(FC);
        n.mask_left  = 4'd0;
      end else if (o) begin
        n.mask_left = c.mask_left - 4'd1;
      end
    end else if (q) begin
      if (cf == c.factor) begin
        n.ack = 1'b1;
      end else begin
        n.pend       = cf;
        n.owed       = 1'b1;
        n.flush_left = 5'(FC);
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] model_state(model_t c);
    if (c.flush_left != 5'd0) return 2'd1;
    if (c.loading)            return 2'd2;
    if (c.mask_left != 4'd0)  return 2'd3;
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, req, fac, ov);
    if (rst) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model state",      32'(state),      32'(model_state(m)));
      check("model filter_rst", 32'(filter_rst), 32'(m.flush_left != 5'd0));
      check("model decim",      32'(decim),      32'(m.factor));
      check("model ack",        32'(cfg_ack),    32'(m.ack));
      check("model busy",       32'(busy),       32'(model_state(m) != 2'd0));
      check("model data_val",   32'(data_val),   32'(ov && (model_state(m) == 2'd0)));
    end
  end

  task automatic cyc(input logic q, input logic [2:0] f);
    req = q;
    fac = f;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic se(input logic q, input logic [2:0] f, input int st, input int frst,
                    input int dec, input int ack, input string tag);
    cyc(q, f);
    check({tag, " state"},      32'(state),      st);
    check({tag, " filter_rst"}, 32'(filter_rst), frst);
    check({tag, " decim"},      32'(decim),      dec);
    check({tag, " ack"},        32'(cfg_ack),    ack);
  endtask

  task automatic power_up(input string tag);
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 1, 1, 1, 0, {tag, " flush"});
    se(1'b0, 3'd0, 2, 0, 1, 0, {tag, " load"});
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 3, 0, 1, 0, {tag, " settle"});
    se(1'b0, 3'd0, 0, 0, 1, 0, {tag, " run"});
    check({tag, " data_val"}, 32'(data_val), 1);
  endtask

  typedef struct packed {
    logic       q;
    logic [2:0] f;
    logic       o;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [31] = '{
    '{1'b1, 3'd2, 1'b0, 2'd1}, '{1'b0, 3'd0, 1'b0, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd1},
    '{1'b0, 3'd0, 1'b0, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd2}, '{1'b0, 3'd0, 1'b1, 2'd3},
    '{1'b0, 3'd0, 1'b1, 2'd3}, '{1'b0, 3'd0, 1'b0, 2'd3}, '{1'b0, 3'd0, 1'b1, 2'd3},
    '{1'b1, 3'd3, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd1},
    '{1'b0, 3'd0, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b0, 2'd2}, '{1'b0, 3'd0, 1'b1, 2'd3},
    '{1'b0, 3'd0, 1'b1, 2'd3}, '{1'b0, 3'd0, 1'b0, 2'd3}, '{1'b0, 3'd0, 1'b1, 2'd3},
    '{1'b0, 3'd0, 1'b0, 2'd3}, '{1'b0, 3'd0, 1'b1, 2'd0}, '{1'b0, 3'd0, 1'b1, 2'd0},
    '{1'b1, 3'd3, 1'b0, 2'd0}, '{1'b1, 3'd0, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd1},
    '{1'b0, 3'd0, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd1}, '{1'b0, 3'd0, 1'b1, 2'd2},
    '{1'b0, 3'd0, 1'b1, 2'd3}, '{1'b0, 3'd0, 1'b1, 2'd3}, '{1'b0, 3'd0, 1'b1, 2'd3},
    '{1'b0, 3'd0, 1'b1, 2'd0}
  };

  initial begin
    // Power-up with OutVal_i high every cycle.
    rst = 1'b1;
    ov  = 1'b1;
    se(1'b0, 3'd0, 1, 1, 1, 0, "reset");
    se(1'b0, 3'd0, 1, 1, 1, 0, "reset hold");
    rst = 1'b0;
    power_up("pwr");

    // Same-factor requests (0 clamps to 1) acknowledge without leaving RUN.
    se(1'b1, 3'd0, 0, 0, 1, 1, "same0 ack");
    check("same0 data_val", 32'(data_val), 1);
    se(1'b0, 3'd0, 0, 0, 1, 0, "same0 ack drop");
    se(1'b1, 3'd1, 0, 0, 1, 1, "same1 ack");
    se(1'b0, 3'd0, 0, 0, 1, 0, "same1 ack drop");

    // Change to factor 4.
    se(1'b1, 3'd4, 1, 1, 1, 0, "f4 flush");
    check("f4 data_val masked", 32'(data_val), 0);
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 1, 1, 1, 0, "f4 flush");
    se(1'b0, 3'd0, 2, 0, 1, 0, "f4 load");
    se(1'b0, 3'd0, 3, 0, 4, 1, "f4 settle ack");
    se(1'b0, 3'd0, 3, 0, 4, 0, "f4 settle");
    se(1'b0, 3'd0, 3, 0, 4, 0, "f4 settle");
    se(1'b0, 3'd0, 0, 0, 4, 0, "f4 run");
    se(1'b1, 3'd4, 0, 0, 4, 1, "same4 ack");
    se(1'b0, 3'd0, 0, 0, 4, 0, "same4 ack drop");

    // Requests 2 and 5 during one flush: latest wins, single ack.
    se(1'b1, 3'd7, 1, 1, 4, 0, "f5 flush");
    se(1'b1, 3'd2, 1, 1, 4, 0, "f5 req2");
    se(1'b1, 3'd5, 1, 1, 4, 0, "f5 req5");
    se(1'b0, 3'd0, 1, 1, 4, 0, "f5 flush");
    se(1'b0, 3'd0, 2, 0, 4, 0, "f5 load");
    se(1'b0, 3'd0, 3, 0, 5, 1, "f5 settle ack");
    se(1'b0, 3'd0, 3, 0, 5, 0, "f5 settle");

    // Request 6 on the second settle cycle aborts into a fresh flush.
    se(1'b1, 3'd6, 1, 1, 5, 0, "f6 abort");
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 1, 1, 5, 0, "f6 flush");
    se(1'b0, 3'd0, 2, 0, 5, 0, "f6 load");
    se(1'b0, 3'd0, 3, 0, 6, 1, "f6 settle ack");
    se(1'b0, 3'd0, 3, 0, 6, 0, "f6 settle");
    se(1'b0, 3'd0, 3, 0, 6, 0, "f6 settle");
    se(1'b0, 3'd0, 0, 0, 6, 0, "f6 run");

    // Request during LOAD: factor 3 loads briefly, then a redo flush loads 6.
    se(1'b1, 3'd3, 1, 1, 6, 0, "redo flush");
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 1, 1, 6, 0, "redo flush");
    se(1'b0, 3'd0, 2, 0, 6, 0, "redo load");
    se(1'b1, 3'd6, 3, 0, 3, 1, "redo settle3");
    se(1'b0, 3'd0, 1, 1, 3, 0, "redo reflush");
    for (int i = 0; i < 3; i++) se(1'b0, 3'd0, 1, 1, 3, 0, "redo reflush");
    se(1'b0, 3'd0, 2, 0, 3, 0, "redo load6");
    se(1'b0, 3'd0, 3, 0, 6, 1, "redo settle6");

    // Reset while settling with factor 6.
    rst = 1'b1;
    se(1'b0, 3'd0, 1, 1, 1, 0, "midreset");
    rst = 1'b0;
    power_up("repwr");

    // OutVal_i gaps, abort-over-exit priority and a clamped change back to 1.
    for (int i = 0; i < 31; i++) begin
      ov = tbl[i].o;
      cyc(tbl[i].q, tbl[i].f);
      check($sformatf("tbl[%0d] state", i), 32'(state), 32'(tbl[i].st));
    end
    check("tbl final decim", 32'(decim), 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
